// File: rtl/axis_pkt_fifo_if.sv
// AXI-stream beat bundle {tdata, tlast, tvalid, tready} shared by the FIFO's upstream and
// downstream sides.
interface axis_pkt_fifo_if #(
  parameter int unsigned D_W = 32
);
  logic signed [D_W-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXI-stream FIFO with first-word fall-through, in cut-through or store-and-forward mode.
// In store-and-forward mode, a packet that fills the FIFO before its tlast arrives is released early.
module axis_pkt_fifo #(
  parameter int unsigned D_W      = 32,
  parameter int unsigned DEPTH    = 16,
  parameter bit          PKT_MODE = 1'b0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  axis_pkt_fifo_if.slave      s_axis,
  axis_pkt_fifo_if.master     m_axis,
  output logic [AW:0]         count_o,
  output logic [AW:0]         pkt_count_o
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] One     = (AW + 1)'(1);

  logic [D_W:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]  count_q, count_d;
  logic [AW:0]  pkt_q, pkt_d;
  logic         s_tready_q;
  logic         rel_q, rel_d;

  logic         empty, full, m_valid;
  logic         wr_en, rd_en, wr_last, rd_last;
  logic [D_W:0] head;

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  always_comb begin
    m_valid = !empty;
    if (PKT_MODE) begin
      m_valid = !empty && ((pkt_q != '0) || full || rel_q);
    end
  end

  assign wr_en   = s_axis.tvalid && s_tready_q;
  assign rd_en   = m_valid && m_axis.tready;
  assign wr_last = wr_en && s_axis.tlast;
  assign rd_last = rd_en && head[D_W];

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + One;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - One;
    end
  end

  always_comb begin
    pkt_d = pkt_q;
    if (wr_last && !rd_last) begin
      pkt_d = pkt_q + One;
    end else if (!wr_last && rd_last) begin
      pkt_d = pkt_q - One;
    end
  end

  // A packet that filled the FIFO streams out until its own tlast leaves.
  always_comb begin
    rel_d = rel_q;
    if (PKT_MODE && full && (pkt_q == '0)) begin
      rel_d = 1'b1;
    end
    if (rd_last) begin
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_q      <= '0;
      s_tready_q <= 1'b0;
      rel_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        wr_ptr_q                <= wr_ptr_q + One;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + One;
      end
      count_q    <= count_d;
      pkt_q      <= pkt_d;
      rel_q      <= rel_d;
      s_tready_q <= (count_d != FullCnt);
    end
  end

  assign s_axis.tready = s_tready_q;
  assign m_axis.tdata  = head[D_W-1:0];
  assign m_axis.tlast  = head[D_W];
  assign m_axis.tvalid = m_valid;
  assign count_o       = count_q;
  assign pkt_count_o   = pkt_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: a cut-through and a store-and-forward instance side by side,
// each checked every cycle against a queue-based model of stored beats.
module tb_axis_pkt_fifo;
  localparam int unsigned DEPTH = 16;
  typedef logic [32:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        sv[2], sl[2], mr[2];
  logic [31:0] sd[2];
  logic        o_sready[2], o_mvalid[2], o_mlast[2];
  logic [31:0] o_mdata[2];
  logic [4:0]  o_cnt[2], o_pc[2];

  beat_t       q[2][$];
  logic [31:0] got[2][$];
  bit          rel[2], sr_exp[2], wrote[2];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  axis_pkt_fifo_if #(.D_W(32)) s0 ();
  axis_pkt_fifo_if #(.D_W(32)) m0 ();
  axis_pkt_fifo_if #(.D_W(32)) s1 ();
  axis_pkt_fifo_if #(.D_W(32)) m1 ();

  assign s0.tdata  = sd[0];
  assign s0.tlast  = sl[0];
  assign s0.tvalid = sv[0];
  assign m0.tready = mr[0];
  assign s1.tdata  = sd[1];
  assign s1.tlast  = sl[1];
  assign s1.tvalid = sv[1];
  assign m1.tready = mr[1];

  assign o_sready[0] = s0.tready;
  assign o_mvalid[0] = m0.tvalid;
  assign o_mlast[0]  = m0.tlast;
  assign o_mdata[0]  = m0.tdata;
  assign o_sready[1] = s1.tready;
  assign o_mvalid[1] = m1.tvalid;
  assign o_mlast[1]  = m1.tlast;
  assign o_mdata[1]  = m1.tdata;

  axis_pkt_fifo #(.D_W(32), .DEPTH(DEPTH), .PKT_MODE(1'b0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s0),
    .m_axis     (m0),
    .count_o    (o_cnt[0]),
    .pkt_count_o(o_pc[0])
  );

  axis_pkt_fifo #(.D_W(32), .DEPTH(DEPTH), .PKT_MODE(1'b1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s1),
    .m_axis     (m1),
    .count_o    (o_cnt[1]),
    .pkt_count_o(o_pc[1])
  );

  function automatic int lasts(int k);
    int n = 0;
    for (int i = 0; i < q[k].size(); i++) if (q[k][i][32]) n++;
    return n;
  endfunction

  // Instance 0 is cut-through; instance 1 holds beats until a whole packet (or a full FIFO).
  function automatic bit exp_valid(int k);
    int n = q[k].size();
    if (n == 0) return 1'b0;
    if (k == 0) return 1'b1;
    return (lasts(k) > 0) || (n == int'(DEPTH)) || rel[k];
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("s_tready", k, o_sready[k], sr_exp[k]);
      chk("m_tvalid", k, o_mvalid[k], exp_valid(k));
      chk("count", k, o_cnt[k], q[k].size());
      chk("pkt_count", k, o_pc[k], lasts(k));
      if (exp_valid(k)) begin
        chk("m_tdata", k, o_mdata[k], q[k][0][31:0]);
        chk("m_tlast", k, o_mlast[k], q[k][0][32]);
      end
    end
  endtask

  // One clock: decide handshakes from the model, advance it at the edge, then compare.
  task automatic tick();
    bit w[2], r[2];
    for (int k = 0; k < 2; k++) begin
      w[k] = !rst && sv[k] && sr_exp[k];
      r[k] = !rst && mr[k] && exp_valid(k);
      if (r[k]) got[k].push_back(o_mdata[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      wrote[k] = w[k];
      if (!rst) begin
        if (k == 1 && q[k].size() == int'(DEPTH) && lasts(k) == 0) rel[k] = 1'b1;
        if (r[k]) begin
          if (q[k][0][32]) rel[k] = 1'b0;
          void'(q[k].pop_front());
        end
        if (w[k]) q[k].push_back({sl[k], sd[k]});
        sr_exp[k] = (q[k].size() != int'(DEPTH));
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      rel[k]    = 1'b0;
      sr_exp[k] = 1'b0;
      wrote[k]  = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] t2[3];
    int          wi;
    int          wc[2];
    bit          hit_full, maxbad;

    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0;
      sl[k] = 1'b0;
      sd[k] = '0;
      mr[k] = 1'b0;
    end

    // Reset and first edge after release
    #2;
    do_reset();
    chk("rst_mdata", 0, o_mdata[0], 0);
    chk("rst_mlast", 1, o_mlast[1], 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("s_tready_pre", 0, o_sready[0], 0);
    tick();
    chk("s_tready_post", 0, o_sready[0], 1);

    // Cut-through: three beats held, then drained in order
    t2[0] = 32'h7FFF_FFFF;
    t2[1] = 32'hFFFF_FFFF;
    t2[2] = 32'd5;
    mr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv[0] = 1'b1;
      sd[0] = t2[i];
      sl[0] = (i == 2);
      tick();
      if (i == 0) chk("t2_valid_first", 0, o_mvalid[0], 1);
    end
    sv[0] = 1'b0;
    sl[0] = 1'b0;
    chk("t2_count", 0, o_cnt[0], 3);
    mr[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", 0, o_mdata[0], t2[i]);
      chk("t2_last", 0, o_mlast[0], (i == 2));
      tick();
    end
    mr[0] = 1'b0;
    chk("t2_empty", 0, o_cnt[0], 0);

    // Full: write blocked while a read frees a slot
    for (int i = 0; i < 16; i++) begin
      sv[0] = 1'b1;
      sd[0] = $urandom;
      sl[0] = (i == 15);
      tick();
    end
    chk("t3_full_cnt", 0, o_cnt[0], 16);
    chk("t3_ready_low", 0, o_sready[0], 0);
    sd[0] = 32'hDEAD_BEEF;
    sl[0] = 1'b0;
    mr[0] = 1'b1;
    tick();
    chk("t3_cnt15", 0, o_cnt[0], 15);
    chk("t3_ready_back", 0, o_sready[0], 1);
    sv[0] = 1'b0;
    for (int c = 0; c < 40 && q[0].size() > 0; c++) tick();
    mr[0] = 1'b0;
    chk("t3_drained", 0, o_cnt[0], 0);

    // Store-and-forward: held until tlast stored
    mr[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sv[1] = 1'b1;
      sd[1] = 32'(100 + i);
      sl[1] = 1'b0;
      tick();
    end
    chk("t4_hold", 1, o_mvalid[1], 0);
    chk("t4_cnt", 1, o_cnt[1], 4);
    sd[1] = 32'd200;
    sl[1] = 1'b1;
    tick();
    sv[1] = 1'b0;
    sl[1] = 1'b0;
    chk("t4_valid", 1, o_mvalid[1], 1);
    chk("t4_pkt", 1, o_pc[1], 1);
    mr[1] = 1'b1;
    repeat (5) tick();
    mr[1] = 1'b0;
    chk("t4_pkt0", 1, o_pc[1], 0);
    chk("t4_cnt0", 1, o_cnt[1], 0);

    // Oversized packet released when full
    got[1].delete();
    wi       = 0;
    hit_full = 1'b0;
    for (int c = 0; c < 200 && got[1].size() < 20; c++) begin
      if (!mr[1] && !sr_exp[1]) begin
        hit_full = 1'b1;
        chk("t5_release", 1, o_mvalid[1], 1);
        chk("t5_pkt0", 1, o_pc[1], 0);
        mr[1] = 1'b1;
      end
      sv[1] = (wi < 20);
      sd[1] = 32'(wi);
      sl[1] = (wi == 19);
      tick();
      if (wrote[1]) wi++;
    end
    sv[1] = 1'b0;
    sl[1] = 1'b0;
    mr[1] = 1'b0;
    chk("t5_hit_full", 1, hit_full, 1);
    chk("t5_beats", 1, got[1].size(), 20);
    for (int i = 0; i < got[1].size(); i++) chk("t5_order", 1, got[1][i], i);

    // Random traffic on both instances
    wc[0]  = 0;
    wc[1]  = 0;
    maxbad = 1'b0;
    for (int c = 0; c < 20000 && (wc[0] < 1000 || wc[1] < 1000); c++) begin
      for (int k = 0; k < 2; k++) begin
        sv[k] = 1'($urandom_range(0, 1));
        sd[k] = $urandom;
        sl[k] = ($urandom_range(0, 3) == 0);
        mr[k] = 1'($urandom_range(0, 1));
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (wrote[k]) wc[k]++;
        if (o_cnt[k] > 5'd16) maxbad = 1'b1;
      end
    end
    chk("t6_beats0", 0, (wc[0] >= 1000), 1);
    chk("t6_beats1", 1, (wc[1] >= 1000), 1);
    chk("t6_cnt_max", 0, maxbad, 0);

    // Mid-stream asynchronous reset
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b1;
      sl[k] = 1'b0;
      sd[k] = 32'h1234_0000;
      mr[k] = 1'b0;
    end
    repeat (3) tick();
    #2;
    for (int k = 0; k < 2; k++) sv[k] = 1'b0;
    do_reset();
    chk("rst_mid_mdata0", 0, o_mdata[0], 0);
    chk("rst_mid_mdata1", 1, o_mdata[1], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_ready", 1, o_sready[1], 1);

    // Sanity after reset: one single-beat packet through each instance
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b1;
      sd[k] = 32'h8000_0000;
      sl[k] = 1'b1;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0;
      sl[k] = 1'b0;
      mr[k] = 1'b1;
      chk("post_data", k, o_mdata[k], 32'h8000_0000);
    end
    tick();
    for (int k = 0; k < 2; k++) chk("post_empty", k, o_cnt[k], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
